seq_serializer: RTL and testbench
=================================

# seq_serializer

Parallel-to-serial bit source for the sequence detector: it accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock as `dout` / `dout_valid`. `dout` connects directly to the detector's `din`, with both blocks on the same `clk` / `rst_n`. A one-word holding buffer allows back-to-back words to stream with no idle bit between them.

## Interface
- `WIDTH`, 32: word length in bits. Minimum 2.
- `MSB_FIRST`, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset: asynchronous, active-low.
- `load_data`  input  WIDTH  word to serialize.
- `load_valid`  input  1  `load_data` is valid.
- `load_ready`  output  1  block can accept a word this cycle.
- `dout`  output  1  serial bit, feeds detector `din`.
- `dout_valid`  output  1  `dout` carries a real bit this cycle.
- `word_done`  output  1  one-cycle pulse during the last bit of each word.
- `busy`  output  1  shifting, or holding buffer occupied.

## Operation
- Storage:
  - shift register `sreg[WIDTH-1:0]`;
  - holding register `hold` with flag `hold_full`;
  - bit counter `bcnt`, width clog2(WIDTH), counts 0..WIDTH-1.
- Transfer: occurs at a rising edge with `load_valid & load_ready`. `load_ready = ~hold_full`, combinational from the flag only.
- FSM states: IDLE, SHIFT.
- IDLE:
  - On transfer: `sreg` <= `load_data`, `bcnt` <= 0, next state SHIFT.
  - Otherwise: stay in IDLE.
  - `hold_full` is always 0 in IDLE.
- SHIFT, `bcnt` < WIDTH-1:
  - Each edge shifts `sreg` by one toward the output end; fill bit is 0.
  - `bcnt` increments.
  - A transfer writes `hold`, and `hold_full` <= 1.
- SHIFT, `bcnt` == WIDTH-1 (last bit, `word_done` = 1):
  - If `hold_full`: `sreg` <= `hold`, `hold_full` <= 0, `bcnt` <= 0, stay in SHIFT.
  - Else, if a transfer occurs this cycle: `sreg` <= `load_data`, `bcnt` <= 0, stay in SHIFT.
  - Else: go to IDLE.
- Outputs:
  - `dout` = `sreg[WIDTH-1]` when MSB_FIRST, `sreg[0]` otherwise, gated to 0 when not in SHIFT.
  - `dout_valid` = (state == SHIFT).
  - `word_done` = SHIFT & (`bcnt` == WIDTH-1).
  - `busy` = SHIFT | `hold_full`.
- All outputs derive from registers only, with no combinational path from inputs to outputs. The one exception is `load_ready`, which derives from `hold_full` alone.
- `load_data` is sampled only at the transfer edge. Changes at any other time have no effect.
- `load_valid` while `load_ready` = 0: ignored. The word is neither stored nor dropped silently; the upstream block must hold it.

## Timing
- Reset values, asserted asynchronously:
  - state IDLE;
  - `sreg`, `hold`, `bcnt`, `hold_full` = 0;
  - `dout` = 0, `dout_valid` = 0, `word_done` = 0, `busy` = 0, `load_ready` = 1.
- Latency: for a transfer at edge k from IDLE, the first bit appears on `dout` after edge k. It is valid for exactly WIDTH consecutive cycles, bit i in cycle k+1+i.
- The detector samples `dout` at the edge following each bit.
- Back-to-back: a second word accepted at any point during SHIFT produces its bit 0 in the cycle immediately after the previous word's last bit. There is no gap.
- Reset mid-word, or with `hold_full`: both words are discarded. Outputs go to reset values immediately, and there is no partial output after release.
- After reset deasserts, the first transfer is possible at the first rising edge.
- Synchronous-release of `rst_n` is the integrator's responsibility. The block only requires that `rst_n` is asynchronous low.

## Test plan
- Reset check: hold `rst_n` = 0 for 2 cycles with `load_valid` = 1 → `dout_valid` = 0, `load_ready` = 1, `dout` = 0. After release, the first edge accepts the word.
- Single word: WIDTH = 32, MSB_FIRST = 1, load 32'hC646_A4A2 →
  - `dout` = 1,1,0,0,0,1,1,0,... for 32 cycles;
  - `word_done` high only in cycle 32;
  - then IDLE, with `dout_valid` = 0 and `busy` = 0.
- Back-to-back: load 32'hC646_A4A2, then 32'hFFFF_0000 two cycles later →
  - `load_ready` = 0 from the second transfer until the first word's last bit;
  - 64 contiguous valid bits;
  - `word_done` pulses at cycles 32 and 64.
- Stall: a third word is offered while `hold_full` = 1 → not accepted. It is accepted on the first edge with `load_ready` = 1, and no word is lost or duplicated.
- Reset mid-operation: assert `rst_n` = 0 at bit 10 of a word, with `hold_full` = 1 → `dout_valid` and `busy` drop within the same cycle. After release, no residual bits appear.
- LSB-first: MSB_FIRST = 0, WIDTH = 8, load 8'b0000_0110 → `dout` = 0,1,1,0,0,0,0,0.

Source files
------------

// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial bit source with a one-word holding buffer.
// Words arrive over a valid/ready handshake and leave one bit per clock on dout.
// A word accepted while another is shifting waits in the holding register and
// follows the current word with no idle cycle in between.
module seq_serializer #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sreg_reg, sreg_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             hold_full_reg, hold_full_next;
  logic [CW-1:0]    bcnt_reg, bcnt_next;

  logic [WIDTH-1:0] shifted;
  logic             xfer;
  logic             last_bit;
  logic             out_bit;

  // The outgoing bit sits at one end of sreg; each shift moves the next bit
  // toward that end and back-fills the far end with zero.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = sreg_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = sreg_reg[gi+1];
        end
      end
    end
  endgenerate

  assign out_bit    = MSB_FIRST ? sreg_reg[WIDTH-1] : sreg_reg[0];
  assign load_ready = ~hold_full_reg;
  assign xfer       = load_valid & ~hold_full_reg;
  assign last_bit   = (bcnt_reg == LAST);

  // State and datapath registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sreg_reg      <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      bcnt_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      sreg_reg      <= sreg_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      bcnt_reg      <= bcnt_next;
    end
  end

  // Next-state logic: load, shift, refill from hold or directly at word end.
  always_comb begin
    state_next     = state_reg;
    sreg_next      = sreg_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    bcnt_next      = bcnt_reg;
    case (state_reg)
      IDLE: begin
        hold_full_next = 1'b0;
        if (xfer) begin
          sreg_next  = load_data;
          bcnt_next  = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          sreg_next = shifted;
          bcnt_next = bcnt_reg + CW'(1);
          if (xfer) begin
            hold_next      = load_data;
            hold_full_next = 1'b1;
          end
        end else if (hold_full_reg) begin
          // Buffered word follows immediately; load_ready is low here.
          sreg_next      = hold_reg;
          hold_full_next = 1'b0;
          bcnt_next      = '0;
        end else if (xfer) begin
          // Word offered during the last bit goes straight into sreg.
          sreg_next = load_data;
          bcnt_next = '0;
        end else begin
          sreg_next  = shifted;
          bcnt_next  = '0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign dout       = (state_reg == SHIFT) & out_bit;
  assign dout_valid = (state_reg == SHIFT);
  assign word_done  = (state_reg == SHIFT) & last_bit;
  assign busy       = (state_reg == SHIFT) | hold_full_reg;

endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: directed bench for seq_serializer with a bit-queue model.
// Two instances: 32-bit MSB-first and 8-bit LSB-first, sharing clock and reset.
module tb_seq_serializer;

  logic        clk;
  logic        rst_n;
  logic [31:0] ld32;
  logic        lv32;
  logic        rdy32, d32, dv32, wd32, busy32;
  logic [7:0]  ld8;
  logic        lv8;
  logic        rdy8, d8, dv8, wd8, busy8;

  int checks = 0;
  int errors = 0;

  seq_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n),
    .load_data(ld32), .load_valid(lv32), .load_ready(rdy32),
    .dout(d32), .dout_valid(dv32), .word_done(wd32), .busy(busy32)
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n),
    .load_data(ld8), .load_valid(lv8), .load_ready(rdy8),
    .dout(d8), .dout_valid(dv8), .word_done(wd8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted word appends its bits, in output order, to a queue.
  // The head of the queue is the bit on dout this cycle; the block can accept
  // a new word whenever at most one word's worth of bits is outstanding.
  bit q32[$];
  bit q8[$];
  bit acc32, acc8;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q32.delete();
      q8.delete();
    end else begin
      acc32 = lv32 && (q32.size() <= 32);
      acc8  = lv8 && (q8.size() <= 8);
      if (q32.size() > 0) void'(q32.pop_front());
      if (q8.size() > 0) void'(q8.pop_front());
      if (acc32) begin
        for (int i = 0; i < 32; i++) q32.push_back(ld32[31-i]);
        $display("xfer w32 data=%h t=%0t", ld32, $time);
      end
      if (acc8) begin
        for (int i = 0; i < 8; i++) q8.push_back(ld8[i]);
        $display("xfer w8  data=%h t=%0t", ld8, $time);
      end
    end
  end

  // Compare every DUT output against the model, mid-cycle.
  always @(negedge clk) begin
    chk1("m32_valid", dv32, q32.size() > 0);
    chk1("m32_dout", d32, (q32.size() > 0) ? q32[0] : 1'b0);
    chk1("m32_done", wd32, (q32.size() % 32) == 1);
    chk1("m32_busy", busy32, q32.size() > 0);
    chk1("m32_ready", rdy32, q32.size() <= 32);
    chk1("m8_valid", dv8, q8.size() > 0);
    chk1("m8_dout", d8, (q8.size() > 0) ? q8[0] : 1'b0);
    chk1("m8_done", wd8, (q8.size() % 8) == 1);
    chk1("m8_busy", busy8, q8.size() > 0);
    chk1("m8_ready", rdy8, q8.size() <= 8);
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [31:0] cap32;
  logic [95:0] cap96;
  logic [7:0]  cap8;
  logic [7:0]  words8 [6];
  int          st;
  int          cnt;

  initial begin
    rst_n = 1'b0;
    lv32  = 1'b1;
    ld32  = 32'hC646_A4A2;
    lv8   = 1'b0;
    ld8   = 8'h00;
    words8 = '{8'hA5, 8'h3C, 8'h81, 8'hFF, 8'h00, 8'h5A};

    // Reset held for two cycles with load_valid asserted.
    repeat (2) begin
      @(negedge clk);
      chk1("rst_valid", dv32, 1'b0);
      chk1("rst_ready", rdy32, 1'b1);
      chk1("rst_dout", d32, 1'b0);
    end
    rst_n = 1'b1;

    // Single word accepted on the first edge after release.
    @(negedge clk);
    lv32 = 1'b0;
    chk1("first_edge_valid", dv32, 1'b1);
    cap32 = '0;
    for (int i = 0; i < 32; i++) begin
      cap32 = {cap32[30:0], d32};
      chk1("single_done", wd32, i == 31);
      @(negedge clk);
    end
    chk32("single_bits", cap32, 32'hC646_A4A2);
    chk1("single_idle_valid", dv32, 1'b0);
    chk1("single_idle_busy", busy32, 1'b0);

    // Back-to-back words plus a third word stalled while hold is full.
    lv32 = 1'b1;
    ld32 = 32'hC646_A4A2;
    @(posedge clk);
    st = 0;
    cap96 = '0;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      cap96 = {cap96[94:0], d32};
      chk1("b2b_valid", dv32, 1'b1);
      chk1("b2b_done", wd32, (i % 32) == 31);
      chk1("b2b_ready", rdy32, !((i >= 2 && i <= 31) || (i >= 33 && i <= 63)));
      if (i == 0) begin
        lv32 = 1'b0;
      end else if (i == 1) begin
        lv32 = 1'b1;
        ld32 = 32'hFFFF_0000;
      end else if (i == 2) begin
        ld32 = 32'h1234_5678;
        st = 1;
      end else if (st == 1 && rdy32) begin
        st = 2;
      end else if (st == 2) begin
        lv32 = 1'b0;
        st = 3;
      end
    end
    chk32("b2b_word0", cap96[95:64], 32'hC646_A4A2);
    chk32("b2b_word1", cap96[63:32], 32'hFFFF_0000);
    chk32("b2b_word2", cap96[31:0], 32'h1234_5678);
    @(negedge clk);
    chk1("b2b_idle", dv32, 1'b0);

    // Reset at bit 10 of a word with the holding buffer full.
    lv32 = 1'b1;
    ld32 = 32'hAAAA_5555;
    @(posedge clk);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i == 0) lv32 = 1'b0;
      if (i == 1) begin
        lv32 = 1'b1;
        ld32 = 32'h0F0F_0F0F;
      end
      if (i == 2) lv32 = 1'b0;
    end
    chk1("prerst_hold_full", rdy32, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_valid", dv32, 1'b0);
    chk1("async_busy", busy32, 1'b0);
    chk1("async_dout", d32, 1'b0);
    chk1("async_ready", rdy32, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk1("post_rst_valid", dv32, 1'b0);
      chk1("post_rst_busy", busy32, 1'b0);
    end

    // LSB-first, 8-bit word.
    lv8 = 1'b1;
    ld8 = 8'b0000_0110;
    @(posedge clk);
    @(negedge clk);
    lv8 = 1'b0;
    cap8 = '0;
    for (int i = 0; i < 8; i++) begin
      cap8[i] = d8;
      chk1("lsb_done", wd8, i == 7);
      @(negedge clk);
    end
    chk32("lsb_bits", {24'b0, cap8}, 32'h0000_0006);
    chk1("lsb_idle", dv8, 1'b0);

    // Stream of 8-bit words, each held until accepted.
    for (int w = 0; w < 6; w++) begin
      ld8 = words8[w];
      lv8 = 1'b1;
      cnt = 0;
      while (!rdy8 && cnt < 50) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 50) chk1("stream_ready_timeout", 1'b0, 1'b1);
      @(negedge clk);
    end
    lv8 = 1'b0;
    repeat (30) @(negedge clk);
    chk1("stream_idle", busy8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
